// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, word-addressed instruction ROM, IF/ID register, counters
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          MEM_DEPTH = 1024,
    parameter int          ADDR_BITS = 10,
    parameter string       INIT_FILE = "instruction_memory.mem",
    parameter logic [31:0] NOP       = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchPC,
    input  logic        Stall_PC,
    input  logic        Stall_ID,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlusFour_ID,
    output logic        Valid_ID,
    output logic [31:0] PC_IF,
    output logic        AlignErr,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    logic [31:0] rom [MEM_DEPTH];

    // Words not covered by the image stay NOP so the ROM never reads X.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = NOP;
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pp4_q, pp4_d;
    logic        valid_q, valid_d;
    logic        align_q, align_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic [31:0] fetch_word;
    logic [31:0] pc_plus_four;
    logic        redirect;
    logic        load_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFFFFFF) ? x : x + 32'd1;
    endfunction

    assign fetch_word   = rom[pc_q[ADDR_BITS+1:2]];
    assign pc_plus_four = pc_q + 32'd4;
    // A stalled decode has unresolved operands, so its branch decision is not trusted.
    assign redirect     = PCSel & ~Stall_ID;
    assign load_valid   = ~Stall_ID & ~redirect & ~Stall_PC;

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pp4_d       = pp4_q;
        valid_d     = valid_q;
        align_d     = align_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (redirect)      pc_d = BranchPC;
        else if (!Stall_PC) pc_d = pc_plus_four;

        if (load_valid) begin
            instr_d     = fetch_word;
            pp4_d       = pc_plus_four;
            valid_d     = 1'b1;
            fetch_cnt_d = sat_inc(fetch_cnt_q);
            if (pc_q[1:0] != 2'b00) align_d = 1'b1;
        end else if (!Stall_ID) begin
            instr_d = NOP;
            pp4_d   = 32'd0;
            valid_d = 1'b0;
        end

        if (redirect)      flush_cnt_d = sat_inc(flush_cnt_q);
        else if (Stall_PC) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP;
            pp4_q       <= 32'd0;
            valid_q     <= 1'b0;
            align_q     <= 1'b0;
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pp4_q       <= pp4_d;
            valid_q     <= valid_d;
            align_q     <= align_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_IF          = pc_q;
    assign Instruction_ID = instr_q;
    assign PCPlusFour_ID  = pp4_q;
    assign Valid_ID       = valid_q;
    assign AlignErr       = align_q;
    assign FetchCount     = fetch_cnt_q;
    assign StallCount     = stall_cnt_q;
    assign FlushCount     = flush_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - randomized and directed bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    localparam int DEPTH = 1024;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        PCSel = 1'b0;
    logic [31:0] BranchPC = 32'd0;
    logic        Stall_PC = 1'b0;
    logic        Stall_ID = 1'b0;
    logic [31:0] Instruction_ID, PCPlusFour_ID, PC_IF, FetchCount, StallCount, FlushCount;
    logic        Valid_ID, AlignErr;

    instruction_fetch_stage #(
        .RESET_PC(32'h00000000), .MEM_DEPTH(DEPTH), .ADDR_BITS(10),
        .INIT_FILE(""), .NOP(32'h00000000)
    ) dut (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchPC(BranchPC),
        .Stall_PC(Stall_PC), .Stall_ID(Stall_ID),
        .Instruction_ID(Instruction_ID), .PCPlusFour_ID(PCPlusFour_ID), .Valid_ID(Valid_ID),
        .PC_IF(PC_IF), .AlignErr(AlignErr), .FetchCount(FetchCount),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_rom [DEPTH];
    logic [31:0] m_pc, m_instr, m_pp4, m_fc, m_sc, m_flc;
    logic        m_valid, m_align;

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_align = 0;
        m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    // One clock edge as the pipeline rules describe it, from the inputs currently applied.
    task automatic model_edge();
        bit taken;
        logic [31:0] word;
        taken = PCSel && !Stall_ID;
        word  = m_rom[(m_pc / 4) % DEPTH];
        if (!Stall_ID) begin
            if (!taken && !Stall_PC) begin
                m_instr = word; m_pp4 = m_pc + 4; m_valid = 1;
                if (m_pc % 4 != 0) m_align = 1;
                if (m_fc != 32'hFFFFFFFF) m_fc = m_fc + 1;
            end else begin
                m_instr = 0; m_pp4 = 0; m_valid = 0;
            end
        end
        if (taken && m_flc != 32'hFFFFFFFF) m_flc = m_flc + 1;
        if (!taken && Stall_PC && m_sc != 32'hFFFFFFFF) m_sc = m_sc + 1;
        if (taken) m_pc = BranchPC;
        else if (!Stall_PC) m_pc = m_pc + 4;
    endtask

    task automatic step(input logic pcsel, input logic [31:0] bpc, input logic spc, input logic sid);
        PCSel = pcsel; BranchPC = bpc; Stall_PC = spc; Stall_ID = sid;
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        PCSel = 0; BranchPC = 0; Stall_PC = 0; Stall_ID = 0;
        Reset = 1;
        #3;
        Reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (PC_IF !== 32'h0 || Instruction_ID !== 32'h0 || PCPlusFour_ID !== 32'h0 || Valid_ID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pipe: pc=%h instr=%h pp4=%h valid=%b, required 0/0/0/0", PC_IF, Instruction_ID, PCPlusFour_ID, Valid_ID);
        end
        n_cmp++;
        if (AlignErr !== 1'b0 || FetchCount !== 0 || StallCount !== 0 || FlushCount !== 0) begin
            n_fail++;
            $display("FAIL reset_stat: align=%b fc=%0d sc=%0d flc=%0d, required all 0", AlignErr, FetchCount, StallCount, FlushCount);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (Instruction_ID !== {8{4'(i + 1)}} || PCPlusFour_ID !== 32'(4 * (i + 1)) || Valid_ID !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: instr=%h pp4=%h valid=%b, required %h/%h/1", i, Instruction_ID, PCPlusFour_ID, Valid_ID, {8{4'(i + 1)}}, 32'(4 * (i + 1)));
            end
        end
        n_cmp++;
        if (FetchCount !== 32'd4 || PC_IF !== 32'h10) begin
            n_fail++;
            $display("FAIL seq_totals: fc=%0d pc=%h, required 4/00000010", FetchCount, PC_IF);
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 32'h40, 0, 0);
        n_cmp++;
        if (Instruction_ID !== 32'h0 || Valid_ID !== 1'b0 || PC_IF !== 32'h40) begin
            n_fail++;
            $display("FAIL branch_bubble: instr=%h valid=%b pc=%h, required 0/0/00000040", Instruction_ID, Valid_ID, PC_IF);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (Instruction_ID !== m_rom[16] || PCPlusFour_ID !== 32'h44 || Valid_ID !== 1'b1 || FlushCount !== 32'd1) begin
            n_fail++;
            $display("FAIL branch_target: instr=%h pp4=%h valid=%b flc=%0d, required %h/00000044/1/1", Instruction_ID, PCPlusFour_ID, Valid_ID, FlushCount, m_rom[16]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        held = Instruction_ID;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        n_cmp++;
        if (PC_IF !== 32'hC || Instruction_ID !== m_rom[2] || Instruction_ID !== held || PCPlusFour_ID !== 32'hC || Valid_ID !== 1'b1 || StallCount !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_hold: pc=%h instr=%h pp4=%h valid=%b sc=%0d, required 0000000c/%h/0000000c/1/2", PC_IF, Instruction_ID, PCPlusFour_ID, Valid_ID, StallCount, m_rom[2]);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (Instruction_ID !== m_rom[3] || PCPlusFour_ID !== 32'h10 || PC_IF !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_resume: instr=%h pp4=%h pc=%h, required %h/00000010/00000010", Instruction_ID, PCPlusFour_ID, PC_IF, m_rom[3]);
        end
    endtask

    task automatic test_priority();
        logic [31:0] instr_before;
        do_reset();
        step(0, 0, 0, 0);
        instr_before = Instruction_ID;
        step(1, 32'h80, 0, 1);
        n_cmp++;
        if (PC_IF !== 32'h8 || FlushCount !== 32'd0 || Instruction_ID !== instr_before) begin
            n_fail++;
            $display("FAIL prio_stall_id: pc=%h flc=%0d instr=%h, required 00000008/0/%h", PC_IF, FlushCount, Instruction_ID, instr_before);
        end
        step(1, 32'h20, 1, 0);
        n_cmp++;
        if (PC_IF !== 32'h20 || Valid_ID !== 1'b0 || StallCount !== 32'd0 || FlushCount !== 32'd1) begin
            n_fail++;
            $display("FAIL prio_redirect: pc=%h valid=%b sc=%0d flc=%0d, required 00000020/0/0/1", PC_IF, Valid_ID, StallCount, FlushCount);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        n_cmp++;
        if (PC_IF !== 32'h24 || StallCount !== 32'd1) begin
            n_fail++;
            $display("FAIL areset_setup: pc=%h sc=%0d, required 00000024/1", PC_IF, StallCount);
        end
        #2;
        Reset = 1;
        #1;
        n_cmp++;
        if (PC_IF !== 32'h0 || Valid_ID !== 1'b0 || Instruction_ID !== 32'h0 || FetchCount !== 0 || StallCount !== 0 || FlushCount !== 0) begin
            n_fail++;
            $display("FAIL areset_now: pc=%h valid=%b instr=%h fc=%0d sc=%0d flc=%0d, required all 0", PC_IF, Valid_ID, Instruction_ID, FetchCount, StallCount, FlushCount);
        end
        #2;
        Reset = 0;
        Stall_PC = 0;
        model_reset();
    endtask

    task automatic test_misalign_wrap();
        do_reset();
        step(0, 0, 0, 0);
        step(1, 32'h6, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (Instruction_ID !== m_rom[1] || PCPlusFour_ID !== 32'hA || AlignErr !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_fetch: instr=%h pp4=%h align=%b, required %h/0000000a/1", Instruction_ID, PCPlusFour_ID, AlignErr, m_rom[1]);
        end
        step(1, 32'h20, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (AlignErr !== 1'b1 || Instruction_ID !== m_rom[9]) begin
            n_fail++;
            $display("FAIL align_sticky: align=%b instr=%h, required 1/%h", AlignErr, Instruction_ID, m_rom[9]);
        end
        step(1, DEPTH * 4, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (Instruction_ID !== m_rom[0] || PCPlusFour_ID !== 32'(DEPTH * 4 + 4)) begin
            n_fail++;
            $display("FAIL addr_wrap: instr=%h pp4=%h, required %h/%h", Instruction_ID, PCPlusFour_ID, m_rom[0], 32'(DEPTH * 4 + 4));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            step($urandom_range(0, 3) == 0, tgt, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            n_cmp++;
            if (PC_IF !== m_pc || Instruction_ID !== m_instr || PCPlusFour_ID !== m_pp4 || Valid_ID !== m_valid) begin
                n_fail++;
                $display("FAIL rand_pipe[%0d]: pc=%h instr=%h pp4=%h valid=%b, required %h/%h/%h/%b", c, PC_IF, Instruction_ID, PCPlusFour_ID, Valid_ID, m_pc, m_instr, m_pp4, m_valid);
            end
            n_cmp++;
            if (AlignErr !== m_align || FetchCount !== m_fc || StallCount !== m_sc || FlushCount !== m_flc) begin
                n_fail++;
                $display("FAIL rand_stat[%0d]: align=%b fc=%0d sc=%0d flc=%0d, required %b/%0d/%0d/%0d", c, AlignErr, FetchCount, StallCount, FlushCount, m_align, m_fc, m_sc, m_flc);
            end
        end
    endtask

    initial begin
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            m_rom[i] = (i < 4) ? {8{4'(i + 1)}} : $urandom;
            dut.rom[i] = m_rom[i];
        end
        @(negedge Clock);
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_priority();
        test_async_reset();
        test_misalign_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
